// File: rtl/mold_itch_pkg.sv
// Shared constants and FSM state type for the MoldUDP64 -> ITCH header decoder.
package mold_itch_pkg;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_ORPHAN = 3'd1;
  localparam logic [2:0] ERR_TRUNC  = 3'd2;
  localparam logic [2:0] ERR_SHORT  = 3'd3;
  localparam logic [2:0] ERR_MASK   = 3'd4;
  localparam logic [2:0] ERR_ZERO   = 3'd5;

  // Byte offsets of the ITCH common header fields within the message.
  localparam int HDR_TYPE_OFF   = 0;
  localparam int HDR_LOCATE_OFF = 1;
  localparam int HDR_TRACK_OFF  = 3;
  localparam int HDR_TS_HI_OFF  = 5;
  localparam int HDR_TS_LO_OFF  = 8;

  localparam int MIN_LEN = 11;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    HDR1 = 3'b010,
    BODY = 3'b100
  } state_t;

endpackage

// File: rtl/cnt_ones_thermo.sv
// Population count of a byte-lane mask; purely combinational, zero latency, no flow control.
module cnt_ones_thermo #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/mold_itch_hdr.sv
// Decodes the ITCH common header from a MoldUDP64 beat stream and forwards beats.
// Data, header and error outputs are registered one cycle; the block never backpressures.
module mold_itch_hdr
  import mold_itch_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int ML_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mold_msg_v_i,
  input  logic              mold_msg_start_i,
  input  logic [ML_W-1:0]   mold_msg_len_i,
  input  logic [KEEP_W-1:0] mold_msg_mask_i,
  input  logic [DATA_W-1:0] mold_msg_data_i,
  output logic              itch_hdr_v_o,
  output logic [7:0]        itch_type_o,
  output logic [15:0]       itch_locate_o,
  output logic [15:0]       itch_track_o,
  output logic [47:0]       itch_ts_o,
  output logic [ML_W-1:0]   itch_len_o,
  output logic              itch_data_v_o,
  output logic              itch_data_start_o,
  output logic              itch_data_last_o,
  output logic [KEEP_W-1:0] itch_data_mask_o,
  output logic [DATA_W-1:0] itch_data_o,
  output logic              itch_err_o,
  output logic [2:0]        itch_err_code_o,
  output logic [31:0]       itch_msg_cnt_o
);

  localparam int PCW = $clog2(KEEP_W + 1);

  state_t            state_q, state_n;
  logic [ML_W-1:0]   remaining_q, remaining_n;
  logic              short_q, short_n;
  logic [PCW-1:0]    pc;
  logic [ML_W-1:0]   pc_w;
  logic              fwd, beat_start, beat_last, mask_ok;
  logic              err_now, hdr_pulse, cnt_inc, lat_hdr0, lat_hdr1;
  logic [2:0]        code;

  logic [31:0]       msg_cnt_q;
  logic              hdr_v_q, data_v_q, data_start_q, data_last_q, err_q;
  logic [2:0]        err_code_q;
  logic [7:0]        type_q;
  logic [15:0]       locate_q, track_q;
  logic [23:0]       ts_hi_q, ts_lo_q;
  logic [ML_W-1:0]   len_q;
  logic [KEEP_W-1:0] mask_q;
  logic [DATA_W-1:0] data_q;

  cnt_ones_thermo #(.W(KEEP_W), .CW(PCW)) u_cnt_ones (
    .bits (mold_msg_mask_i),
    .cnt  (pc)
  );

  assign pc_w = ML_W'(pc);

  always_comb begin
    state_n     = state_q;
    remaining_n = remaining_q;
    short_n     = short_q;
    fwd         = 1'b0;
    beat_start  = 1'b0;
    beat_last   = 1'b0;
    mask_ok     = 1'b1;
    err_now     = 1'b0;
    code        = ERR_NONE;
    hdr_pulse   = 1'b0;
    cnt_inc     = 1'b0;
    lat_hdr0    = 1'b0;
    lat_hdr1    = 1'b0;
    if (mold_msg_v_i) begin
      if (mold_msg_start_i) begin
        if (mold_msg_len_i == '0) begin
          err_now = 1'b1;
          code    = ERR_ZERO;
          state_n = IDLE;
        end else begin
          fwd         = 1'b1;
          beat_start  = 1'b1;
          beat_last   = (mold_msg_len_i <= ML_W'(KEEP_W));
          remaining_n = mold_msg_len_i - pc_w;
          short_n     = (mold_msg_len_i < ML_W'(MIN_LEN));
          if (mold_msg_len_i < ML_W'(MIN_LEN)) begin
            // Too short for a header: pass through without decoding.
            err_now = 1'b1;
            code    = ERR_SHORT;
            state_n = beat_last ? IDLE : BODY;
          end else begin
            lat_hdr0 = 1'b1;
            if (!(&mold_msg_mask_i)) begin
              err_now = 1'b1;
              code    = ERR_MASK;
              state_n = IDLE;
            end else begin
              state_n = HDR1;
            end
          end
        end
        // An interrupted message is the more important event to report.
        if (state_q != IDLE) begin
          err_now = 1'b1;
          code    = ERR_TRUNC;
        end
      end else if (state_q == IDLE) begin
        err_now = 1'b1;
        code    = ERR_ORPHAN;
      end else begin
        fwd         = 1'b1;
        beat_last   = (remaining_q <= ML_W'(KEEP_W));
        remaining_n = remaining_q - pc_w;
        mask_ok     = beat_last ? (pc_w == remaining_q) : (&mold_msg_mask_i);
        if (state_q == HDR1) begin
          lat_hdr1  = 1'b1;
          hdr_pulse = 1'b1;
        end
        if (!mask_ok) begin
          err_now = 1'b1;
          code    = ERR_MASK;
          state_n = IDLE;
        end else if (beat_last) begin
          cnt_inc = !short_q;
          state_n = IDLE;
        end else begin
          state_n = BODY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      short_q      <= 1'b0;
      msg_cnt_q    <= '0;
      hdr_v_q      <= 1'b0;
      data_v_q     <= 1'b0;
      data_start_q <= 1'b0;
      data_last_q  <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_n;
      remaining_q  <= remaining_n;
      short_q      <= short_n;
      if (cnt_inc) begin
        msg_cnt_q <= msg_cnt_q + 32'd1;
      end
      hdr_v_q      <= hdr_pulse;
      data_v_q     <= fwd;
      data_start_q <= fwd & beat_start;
      data_last_q  <= fwd & beat_last;
      err_q        <= err_now;
      err_code_q   <= code;
    end
  end

  // Payload registers are qualified by their valids and carry no reset.
  always_ff @(posedge clk) begin
    if (lat_hdr0) begin
      type_q   <= mold_msg_data_i[8*HDR_TYPE_OFF +: 8];
      locate_q <= {mold_msg_data_i[8*HDR_LOCATE_OFF +: 8],
                   mold_msg_data_i[8*(HDR_LOCATE_OFF+1) +: 8]};
      track_q  <= {mold_msg_data_i[8*HDR_TRACK_OFF +: 8],
                   mold_msg_data_i[8*(HDR_TRACK_OFF+1) +: 8]};
      ts_hi_q  <= {mold_msg_data_i[8*HDR_TS_HI_OFF +: 8],
                   mold_msg_data_i[8*(HDR_TS_HI_OFF+1) +: 8],
                   mold_msg_data_i[8*(HDR_TS_HI_OFF+2) +: 8]};
      len_q    <= mold_msg_len_i;
    end
    if (lat_hdr1) begin
      ts_lo_q <= {mold_msg_data_i[8*(HDR_TS_LO_OFF-KEEP_W) +: 8],
                  mold_msg_data_i[8*(HDR_TS_LO_OFF-KEEP_W+1) +: 8],
                  mold_msg_data_i[8*(HDR_TS_LO_OFF-KEEP_W+2) +: 8]};
    end
    if (fwd) begin
      mask_q <= mold_msg_mask_i;
      data_q <= mold_msg_data_i;
    end
  end

  assign itch_hdr_v_o      = hdr_v_q;
  assign itch_type_o       = type_q;
  assign itch_locate_o     = locate_q;
  assign itch_track_o      = track_q;
  assign itch_ts_o         = {ts_hi_q, ts_lo_q};
  assign itch_len_o        = len_q;
  assign itch_data_v_o     = data_v_q;
  assign itch_data_start_o = data_start_q;
  assign itch_data_last_o  = data_last_q;
  assign itch_data_mask_o  = mask_q;
  assign itch_data_o       = data_q;
  assign itch_err_o        = err_q;
  assign itch_err_code_o   = err_code_q;
  assign itch_msg_cnt_o    = msg_cnt_q;

endmodule

// File: tb/tb_mold_itch_hdr.sv
// Scoreboard bench for mold_itch_hdr: expected beats, headers and error codes queued at drive time.
module tb_mold_itch_hdr;

  logic        clk = 1'b0;
  logic        reset;
  logic        v, start;
  logic [15:0] len;
  logic [7:0]  mask;
  logic [63:0] data;

  logic        itch_hdr_v_o;
  logic [7:0]  itch_type_o;
  logic [15:0] itch_locate_o, itch_track_o;
  logic [47:0] itch_ts_o;
  logic [15:0] itch_len_o;
  logic        itch_data_v_o, itch_data_start_o, itch_data_last_o;
  logic [7:0]  itch_data_mask_o;
  logic [63:0] itch_data_o;
  logic        itch_err_o;
  logic [2:0]  itch_err_code_o;
  logic [31:0] itch_msg_cnt_o;

  always #5 clk = ~clk;

  mold_itch_hdr #(.DATA_W(64), .KEEP_W(8), .ML_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .mold_msg_v_i      (v),
    .mold_msg_start_i  (start),
    .mold_msg_len_i    (len),
    .mold_msg_mask_i   (mask),
    .mold_msg_data_i   (data),
    .itch_hdr_v_o      (itch_hdr_v_o),
    .itch_type_o       (itch_type_o),
    .itch_locate_o     (itch_locate_o),
    .itch_track_o      (itch_track_o),
    .itch_ts_o         (itch_ts_o),
    .itch_len_o        (itch_len_o),
    .itch_data_v_o     (itch_data_v_o),
    .itch_data_start_o (itch_data_start_o),
    .itch_data_last_o  (itch_data_last_o),
    .itch_data_mask_o  (itch_data_mask_o),
    .itch_data_o       (itch_data_o),
    .itch_err_o        (itch_err_o),
    .itch_err_code_o   (itch_err_code_o),
    .itch_msg_cnt_o    (itch_msg_cnt_o)
  );

  typedef struct packed {
    logic        start;
    logic        last;
    logic [7:0]  mask;
    logic [63:0] data;
  } beat_t;

  typedef struct packed {
    logic [7:0]  typ;
    logic [15:0] locate;
    logic [15:0] track;
    logic [47:0] ts;
    logic [15:0] len;
  } hdr_t;

  beat_t       dq[$];
  hdr_t        hq[$];
  logic [2:0]  eq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_cnt = 32'd0;

  beat_t      mon_b, exp_b;
  hdr_t       mon_h, exp_h;
  logic [2:0] exp_e;

  // Output monitor: every forwarded beat, header pulse and error pulse must match the queue head.
  always @(negedge clk) begin
    if (itch_data_v_o) begin
      vectors++;
      mon_b = {itch_data_start_o, itch_data_last_o, itch_data_mask_o, itch_data_o};
      if (dq.size() == 0) begin
        miscompares++;
        $display("FAIL data_unexpected: got %h, required no beat", mon_b);
      end else begin
        exp_b = dq.pop_front();
        if (mon_b !== exp_b) begin
          miscompares++;
          $display("FAIL data_beat: got %h, required %h", mon_b, exp_b);
        end
      end
    end
    if (itch_hdr_v_o) begin
      vectors++;
      mon_h = {itch_type_o, itch_locate_o, itch_track_o, itch_ts_o, itch_len_o};
      if (hq.size() == 0) begin
        miscompares++;
        $display("FAIL hdr_unexpected: got %h, required no header", mon_h);
      end else begin
        exp_h = hq.pop_front();
        if (mon_h !== exp_h) begin
          miscompares++;
          $display("FAIL hdr_fields: got %h, required %h", mon_h, exp_h);
        end
      end
    end
    if (itch_err_o) begin
      vectors++;
      if (eq.size() == 0) begin
        miscompares++;
        $display("FAIL err_unexpected: got code %0d, required no error", itch_err_code_o);
      end else begin
        exp_e = eq.pop_front();
        if (itch_err_code_o !== exp_e) begin
          miscompares++;
          $display("FAIL err_code: got %0d, required %0d", itch_err_code_o, exp_e);
        end
      end
    end else if (itch_err_code_o !== 3'd0) begin
      vectors++;
      miscompares++;
      $display("FAIL err_code_idle: got %0d, required 0", itch_err_code_o);
    end
  end

  function automatic logic [63:0] pat(input logic [7:0] base, input int b);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = base + 8'(8*b + i);
    return d;
  endfunction

  function automatic hdr_t hdr_of(input logic [7:0] base, input logic [15:0] l);
    hdr_t h;
    h.typ    = base;
    h.locate = {base + 8'd1, base + 8'd2};
    h.track  = {base + 8'd3, base + 8'd4};
    h.ts     = {base + 8'd5, base + 8'd6, base + 8'd7, base + 8'd8, base + 8'd9, base + 8'd10};
    h.len    = l;
    return h;
  endfunction

  task automatic send_beat(input logic s, input logic [15:0] l, input logic [7:0] m,
                           input logic [63:0] d, input logic fwd, input logic last);
    beat_t b;
    @(negedge clk);
    v = 1'b1; start = s; len = l; mask = m; data = d;
    if (fwd) begin
      b.start = s; b.last = last; b.mask = m; b.data = d;
      dq.push_back(b);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    v = 1'b0; start = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] base, input int l);
    int rem;
    int b;
    int n;
    logic [7:0] m;
    rem = l;
    b = 0;
    if (l >= 11) begin
      hq.push_back(hdr_of(base, 16'(l)));
      exp_cnt++;
    end
    while (rem > 0) begin
      n = (rem > 8) ? 8 : rem;
      m = 8'((1 << n) - 1);
      send_beat(b == 0, 16'(l), m, pat(base, b), 1'b1, rem <= 8);
      rem -= n;
      b++;
    end
    idle();
  endtask

  task automatic check_end(input string name);
    repeat (3) @(negedge clk);
    vectors++;
    if (dq.size() != 0) begin
      miscompares++;
      $display("FAIL %s data_missing: got %0d beats pending, required 0", name, dq.size());
    end
    vectors++;
    if (hq.size() != 0) begin
      miscompares++;
      $display("FAIL %s hdr_missing: got %0d headers pending, required 0", name, hq.size());
    end
    vectors++;
    if (eq.size() != 0) begin
      miscompares++;
      $display("FAIL %s err_missing: got %0d errors pending, required 0", name, eq.size());
    end
    vectors++;
    if (itch_msg_cnt_o !== exp_cnt) begin
      miscompares++;
      $display("FAIL %s msg_cnt: got %0d, required %0d", name, itch_msg_cnt_o, exp_cnt);
    end
    dq.delete();
    hq.delete();
    eq.delete();
  endtask

  task automatic check_quiet(input string name);
    vectors++;
    if ({itch_hdr_v_o, itch_data_v_o, itch_data_start_o, itch_data_last_o, itch_err_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL %s valids: got %b, required 00000", name,
               {itch_hdr_v_o, itch_data_v_o, itch_data_start_o, itch_data_last_o, itch_err_o});
    end
    vectors++;
    if (itch_msg_cnt_o !== 32'd0 || itch_err_code_o !== 3'd0) begin
      miscompares++;
      $display("FAIL %s cnt_code: got cnt=%0d code=%0d, required 0/0", name, itch_msg_cnt_o, itch_err_code_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
  endtask

  task automatic test_decode();
    hdr_t h;
    h.typ = 8'h41; h.locate = 16'h0007; h.track = 16'h0001;
    h.ts = 48'h0000_1234_5678; h.len = 16'd11;
    hq.push_back(h);
    send_beat(1'b1, 16'd11, 8'hFF, 64'h1200_0001_0007_0041, 1'b1, 1'b0);
    send_beat(1'b0, 16'd11, 8'h07, 64'h0000_0000_0078_5634, 1'b1, 1'b1);
    idle();
    exp_cnt++;
    check_end("decode");
  endtask

  task automatic test_long();
    send_good(8'h10, 36);
    send_good(8'h50, 17);
    check_end("long");
  endtask

  task automatic test_back_to_back();
    send_beat(1'b1, 16'd20, 8'hFF, pat(8'h20, 0), 1'b1, 1'b0);
    eq.push_back(3'd2);
    send_good(8'h30, 11);
    check_end("trunc");
  endtask

  task automatic test_short();
    eq.push_back(3'd3);
    send_beat(1'b1, 16'd6, 8'h3F, pat(8'h60, 0), 1'b1, 1'b1);
    idle();
    check_end("short");
  endtask

  task automatic test_mask_orphan();
    send_beat(1'b1, 16'd16, 8'hFF, pat(8'h70, 0), 1'b1, 1'b0);
    hq.push_back(hdr_of(8'h70, 16'd16));
    eq.push_back(3'd4);
    send_beat(1'b0, 16'd16, 8'h7F, pat(8'h70, 1), 1'b1, 1'b1);
    eq.push_back(3'd1);
    send_beat(1'b0, 16'd16, 8'hFF, pat(8'h80, 0), 1'b0, 1'b0);
    idle();
    check_end("mask_orphan");
  endtask

  task automatic test_zero();
    eq.push_back(3'd5);
    send_beat(1'b1, 16'd0, 8'h00, pat(8'h88, 0), 1'b0, 1'b0);
    idle();
    send_good(8'h90, 11);
    check_end("zero");
  endtask

  task automatic test_reset_mid();
    hq.push_back(hdr_of(8'hA0, 16'd40));
    send_beat(1'b1, 16'd40, 8'hFF, pat(8'hA0, 0), 1'b1, 1'b0);
    send_beat(1'b0, 16'd40, 8'hFF, pat(8'hA0, 1), 1'b1, 1'b0);
    send_beat(1'b0, 16'd40, 8'hFF, pat(8'hA0, 2), 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1; v = 1'b0; start = 1'b0;
    @(negedge clk);
    check_quiet("reset_mid");
    exp_cnt = 32'd0;
    reset = 1'b0;
    check_end("reset_mid_drop");
    send_good(8'hB0, 11);
    check_end("reset_mid_next");
  endtask

  initial begin
    reset = 1'b1; v = 1'b0; start = 1'b0; len = '0; mask = '0; data = '0;
    test_reset();
    test_decode();
    test_long();
    test_back_to_back();
    test_short();
    test_mask_orphan();
    test_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mold_itch_hdr.md
MOLD_ITCH_HDR -- requirements
Module: mold_itch_hdr

Interface
REQ-001 SHALL have parameter DATA_W, 64, message beat width in bits.
REQ-002 SHALL have parameter KEEP_W, 8, byte-lane mask width.
REQ-003 SHALL have parameter ML_W, 16, message length field width.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports mold_msg_v_i / mold_msg_start_i  in  1 each  beat valid / first beat of a message.
REQ-007 SHALL have port mold_msg_len_i  in  ML_W  message byte length; sampled on the start beat only.
REQ-008 SHALL have ports mold_msg_mask_i  in  KEEP_W  and mold_msg_data_i  in  DATA_W; message byte k sits in lane k mod 8 (data[8k+7:8k]).
REQ-009 SHALL have outputs itch_hdr_v_o 1, itch_type_o 8, itch_locate_o 16, itch_track_o 16, itch_ts_o 48, itch_len_o ML_W: decoded ITCH common header.
REQ-010 SHALL have outputs itch_data_v_o 1, itch_data_start_o 1, itch_data_last_o 1, itch_data_mask_o KEEP_W, itch_data_o DATA_W: registered beat pass-through.
REQ-011 SHALL have outputs itch_err_o 1 (error pulse), itch_err_code_o 3, and itch_msg_cnt_o 32 (good messages seen).

Function
REQ-012 SHALL never backpressure; every valid beat is consumed the cycle it arrives.
REQ-013 SHALL run FSM IDLE -> HDR1 -> BODY -> IDLE, one-hot encoded.
REQ-014 IDLE + valid start beat, len >= 11: SHALL latch type (byte 0), locate (bytes 1-2), track (bytes 3-4), ts[47:24] (bytes 5-7), and remaining = len - popcount(mask); then go to HDR1.
REQ-015 Multi-byte fields SHALL be big-endian (the lowest-numbered byte is the MSB).
REQ-016 HDR1 + valid non-start beat: SHALL latch ts[23:0] from bytes 8-10 and pulse itch_hdr_v_o for one cycle on the next edge; then go to BODY, or to IDLE if this beat is last.
REQ-017 A beat SHALL be last when remaining <= 8 before the beat; remaining decrements by popcount(mask) on every beat.
REQ-018 Each accepted beat SHALL appear on the itch_data_* outputs exactly 1 cycle later; start and last are set per REQ-014/REQ-017.
REQ-019 On a last beat with popcount(mask) == remaining: itch_msg_cnt_o SHALL increment (wrapping at 2^32) and the FSM returns to IDLE.
REQ-020 Mask mismatch: if popcount(mask) != remaining on the last beat, or the mask is not all-ones on a non-last beat, SHALL raise error code 4 (MASK), drop to IDLE, and leave the count unchanged.
REQ-021 Start beat with len in 1..10: SHALL raise code 3 (SHORT), emit no header, and pass the beats through BODY until the length is consumed.
REQ-022 Start beat with len == 0: SHALL raise code 5 (ZERO), stay in IDLE, and forward no data.
REQ-023 Start beat while in HDR1/BODY: SHALL raise code 2 (TRUNC), abandon the old message, and process the new start per REQ-014/REQ-021/REQ-022 in the same cycle.
REQ-024 Non-start beat in IDLE: SHALL raise code 1 (ORPHAN) and drop the beat (not forwarded).
REQ-025 itch_err_o SHALL be a one-cycle pulse, registered like the data; itch_err_code_o is 0 when no error.
REQ-026 Cycles without a valid beat SHALL hold the FSM and counters unchanged.

Reset
REQ-027 reset SHALL force IDLE, remaining = 0, and itch_msg_cnt_o = 0.
REQ-028 reset SHALL drive every *_v_o, itch_err_o, itch_data_start_o and itch_data_last_o to 0 and itch_err_code_o to 0.
REQ-029 Reset asserted mid-message SHALL discard the message silently, with no error pulse.
REQ-030 Field and data registers SHALL need no reset; they are qualified by their valids.

Structure
REQ-031 Package mold_itch_pkg SHALL hold the error-code constants, the header byte offsets, the minimum length (11) and the FSM state type.
REQ-032 Byte counting SHALL reuse the existing cnt_ones_thermo sub-module on mold_msg_mask_i; there is no other sub-module.

Verification
REQ-033 len=11, beat0 bytes 41 00 07 00 01 00 00 12 mask FF, beat1 34 56 78 mask 07 -> hdr_v on 1 cycle, type=0x41, locate=7, track=1, ts=0x0000_1234_5678, cnt=1, last on beat1.
REQ-034 len=36, 5 beats, final mask 0F -> 1 hdr_v, data start/last on beats 1/5, each beat delayed 1 cycle, cnt+1, no error.
REQ-035 len=20, new start on beat 2 -> err code 2 pulse, the new message decodes normally, the count increments only for the second message.
REQ-036 len=6 start, mask 3F -> err code 3, no hdr_v, one data beat with start=last=1.
REQ-037 len=16, second beat mask 7F -> err code 4, count unchanged; a following orphan non-start beat -> err code 1 and is not forwarded.
REQ-038 Reset during BODY of a len=40 message -> all valids 0, count 0, no error; the next len=11 message decodes correctly.
